// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MCU results
// queue in a small FIFO, and a starvation counter forces a one-cycle pipeline
// stall so a waiting MCU result always drains.
module wb_port_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_BITS   = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_we,
  input  logic [REG_BITS-1:0]           pipe_wa,
  input  logic [WIDTH-1:0]              pipe_wd,
  input  logic                          mcu_valid,
  output logic                          mcu_ready,
  input  logic [REG_BITS-1:0]           mcu_wa,
  input  logic [WIDTH-1:0]              mcu_wd,
  output logic                          stall_pipe,
  output logic                          rf_we,
  output logic [REG_BITS-1:0]           rf_wa,
  output logic [WIDTH-1:0]              rf_wd,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [PW-1:0] FULL = PW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FORCE
  } state_t;

  logic [REG_BITS-1:0] wa_mem [FIFO_DEPTH];
  logic [WIDTH-1:0]    wd_mem [FIFO_DEPTH];

  state_t              state_q, state_d;
  logic                stall_q, stall_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [PW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       rd_ptr_q, wr_ptr_q;
  logic                rf_we_q;
  logic [REG_BITS-1:0] rf_wa_q;
  logic [WIDTH-1:0]    rf_wd_q;

  logic                push, pop, fifo_ne, grant_pipe, force_d;
  logic [REG_BITS-1:0] head_wa;
  logic [WIDTH-1:0]    head_wd;

  assign head_wa    = wa_mem[rd_ptr_q];
  assign head_wd    = wd_mem[rd_ptr_q];
  assign stall_pipe = stall_q;
  assign rf_we      = rf_we_q;
  assign rf_wa      = rf_wa_q;
  assign rf_wd      = rf_wd_q;
  assign pending    = cnt_q;

  // Grant decision, FIFO occupancy, starvation counter and next state.
  always_comb begin
    mcu_ready  = (cnt_q != FULL);
    push       = mcu_valid && mcu_ready;
    fifo_ne    = (cnt_q != '0);
    grant_pipe = !stall_q && pipe_we;
    pop        = !grant_pipe && fifo_ne;

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + PW'(1);
      2'b01:   cnt_d = cnt_q - PW'(1);
      default: cnt_d = cnt_q;
    endcase

    wait_d = wait_q;
    if (pop) begin
      wait_d = '0;
    end else if (fifo_ne && (wait_q != WMAX)) begin
      wait_d = wait_q + WW'(1);
    end

    // The stall is raised in the cycle right after the head's last denial.
    force_d = fifo_ne && !pop && (wait_d == WMAX);

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = push ? PEND : IDLE;
      PEND: begin
        if (force_d) begin
          state_d = FORCE;
        end else if (cnt_d == '0) begin
          state_d = IDLE;
        end
      end
      FORCE:   state_d = (cnt_d != '0) ? PEND : IDLE;
      default: state_d = IDLE;
    endcase

    stall_d = (state_d == FORCE);
  end

  // MCU result storage; contents are don't-care while not counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      wa_mem[wr_ptr_q] <= mcu_wa;
      wd_mem[wr_ptr_q] <= mcu_wd;
    end
  end

  // Arbiter FSM with registered stall and register-file outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      stall_q  <= 1'b0;
      wait_q   <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rf_we_q  <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      rf_we_q <= grant_pipe || pop;
      if (grant_pipe) begin
        rf_wa_q <= pipe_wa;
        rf_wd_q <= pipe_wd;
      end else if (pop) begin
        rf_wa_q <= head_wa;
        rf_wd_q <= head_wd;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned REG_BITS   = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned MAX_WAIT   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                pipe_we;
  logic [REG_BITS-1:0] pipe_wa;
  logic [WIDTH-1:0]    pipe_wd;
  logic                mcu_valid;
  logic                mcu_ready;
  logic [REG_BITS-1:0] mcu_wa;
  logic [WIDTH-1:0]    mcu_wd;
  logic                stall_pipe;
  logic                rf_we;
  logic [REG_BITS-1:0] rf_wa;
  logic [WIDTH-1:0]    rf_wd;
  logic [1:0]          pending;

  wb_port_arbiter #(
    .WIDTH(WIDTH),
    .REG_BITS(REG_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pipe_we(pipe_we),
    .pipe_wa(pipe_wa),
    .pipe_wd(pipe_wd),
    .mcu_valid(mcu_valid),
    .mcu_ready(mcu_ready),
    .mcu_wa(mcu_wa),
    .mcu_wd(mcu_wd),
    .stall_pipe(stall_pipe),
    .rf_we(rf_we),
    .rf_wa(rf_wa),
    .rf_wd(rf_wd),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: queue of waiting results, denial count of the head,
  // expected register-file outputs and stall flag.
  typedef struct packed {
    logic [REG_BITS-1:0] wa;
    logic [WIDTH-1:0]    wd;
  } ent_t;

  ent_t                q[$];
  int                  denied;
  logic                m_we, m_stall;
  logic [REG_BITS-1:0] m_wa;
  logic [WIDTH-1:0]    m_wd;

  // Current MCU offer; held until the model says it was accepted.
  logic                off_v = 1'b0;
  logic [REG_BITS-1:0] off_wa = '0;
  logic [WIDTH-1:0]    off_wd = '0;

  task automatic model_reset();
    q.delete();
    denied  = 0;
    m_we    = 1'b0;
    m_wa    = '0;
    m_wd    = '0;
    m_stall = 1'b0;
  endtask

  task automatic model_step(input logic pwe, input logic [REG_BITS-1:0] pwa,
                            input logic [WIDTH-1:0] pwd, output logic acc);
    int n;
    ent_t e;
    n   = q.size();
    acc = off_v && (n != int'(FIFO_DEPTH));
    if (!m_stall && pwe) begin
      m_we = 1'b1; m_wa = pwa; m_wd = pwd;
      if (n > 0) denied++;
    end else if (n > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_wa = e.wa; m_wd = e.wd;
      denied = 0;
    end else begin
      m_we = 1'b0;
    end
    m_stall = (n > 0) && (denied == int'(MAX_WAIT));
    if (acc) begin
      e.wa = off_wa; e.wd = off_wd;
      q.push_back(e);
    end
  endtask

  task automatic check_all();
    check("rf_we", 64'(rf_we), 64'(m_we));
    check("rf_wa", 64'(rf_wa), 64'(m_wa));
    check("rf_wd", 64'(rf_wd), 64'(m_wd));
    check("stall_pipe", 64'(stall_pipe), 64'(m_stall));
    check("pending", 64'(pending), 64'(q.size()));
    check("mcu_ready", 64'(mcu_ready), 64'(q.size() != int'(FIFO_DEPTH)));
  endtask

  // Called just after a falling edge: check, drive, advance model, wait one cycle.
  task automatic step(input logic pwe, input logic [REG_BITS-1:0] pwa, input logic [WIDTH-1:0] pwd);
    logic acc;
    check_all();
    pipe_we   = pwe;
    pipe_wa   = pwa;
    pipe_wd   = pwd;
    mcu_valid = off_v;
    mcu_wa    = off_wa;
    mcu_wd    = off_wd;
    model_step(pwe, pwa, pwd, acc);
    if (acc) off_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic offer(input logic [REG_BITS-1:0] wa, input logic [WIDTH-1:0] wd);
    off_v = 1'b1; off_wa = wa; off_wd = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, stalls;
    rst = 1'b1; pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0;
    mcu_valid = 1'b0; mcu_wa = '0; mcu_wd = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("reset_rf_we", 64'(rf_we), 64'd0);
    check("reset_rf_wa", 64'(rf_wa), 64'd0);
    check("reset_rf_wd", 64'(rf_wd), 64'd0);
    check("reset_stall", 64'(stall_pipe), 64'd0);
    check("reset_pending", 64'(pending), 64'd0);
    check("reset_ready", 64'(mcu_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Pipeline only.
    step(1'b1, 4'd3, 32'h00AABBCC);
    check("pipe_we", 64'(rf_we), 64'd1);
    check("pipe_wa", 64'(rf_wa), 64'd3);
    check("pipe_wd", 64'(rf_wd), 64'h00AABBCC);

    // MCU only.
    offer(4'd5, 32'h00112222);
    step(1'b0, '0, '0);
    check("mcu_pending1", 64'(pending), 64'd1);
    check("mcu_no_write", 64'(rf_we), 64'd0);
    step(1'b0, '0, '0);
    check("mcu_wa", 64'(rf_wa), 64'd5);
    check("mcu_wd", 64'(rf_wd), 64'h00112222);
    check("mcu_pending0", 64'(pending), 64'd0);

    // Starvation: pipeline writes continuously, MCU result must get through.
    offer(4'd7, 32'h0000BEEF);
    step(1'b1, 4'd1, 32'h00001122);
    lat = 1; stalls = 0;
    while (lat < 20 && !(rf_we && rf_wa == 4'd7)) begin
      if (stall_pipe) stalls++;
      step(1'b1, 4'd1, 32'h00001122);
      lat++;
    end
    check("starve_latency", 64'(lat), 64'(MAX_WAIT + 2));
    check("starve_stalls", 64'(stalls), 64'd1);
    step(1'b1, 4'd1, 32'h00001122);
    check("starve_resume_wa", 64'(rf_wa), 64'd1);

    // Full FIFO with pipeline busy; third result held off, order preserved.
    offer(4'd8, 32'hA0A0A0A0);
    step(1'b1, 4'd2, 32'h00000022);
    offer(4'd9, 32'hB0B0B0B0);
    step(1'b1, 4'd2, 32'h00000022);
    check("full_pending", 64'(pending), 64'd2);
    check("full_ready", 64'(mcu_ready), 64'd0);
    offer(4'd10, 32'hC0C0C0C0);
    for (int i = 0; i < 20 && off_v; i++) step(1'b1, 4'd2, 32'h00000022);
    check("full_accepted", 64'(off_v), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0);

    // Simultaneous push and pop at one entry.
    offer(4'd11, 32'hD0D0D0D0);
    step(1'b0, '0, '0);
    offer(4'd12, 32'hE0E0E0E0);
    step(1'b0, '0, '0);
    check("simul_pending", 64'(pending), 64'd1);
    check("simul_old_head", 64'(rf_wa), 64'd11);
    step(1'b0, '0, '0);
    check("simul_new_head", 64'(rf_wa), 64'd12);

    // Randomized traffic at two pipeline loads.
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 400; i++) begin
        if (!off_v && $urandom_range(0, 99) < 45)
          offer(REG_BITS'($urandom), $urandom);
        step(($urandom_range(0, 99) < (phase == 0 ? 90 : 35)), REG_BITS'($urandom), $urandom);
      end
    end

    // Asynchronous reset mid-cycle with one entry held.
    off_v = 1'b0;
    for (int i = 0; i < 12 && (q.size() != 0); i++) step(1'b0, '0, '0);
    offer(4'd6, 32'h00006666);
    step(1'b1, 4'd4, 32'h00004444);
    pipe_we = 1'b1; mcu_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_pending", 64'(pending), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_pending", 64'(pending), 64'd0);
    check("async_rst_ready", 64'(mcu_ready), 64'd1);
    check("async_rst_rf_we", 64'(rf_we), 64'd0);
    check("async_rst_stall", 64'(stall_pipe), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pipe_we = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0);
    check_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
